irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt source controller driving the CP0 ir_in line. Latches rising edges of external
//  request lines plus an internal compare timer into a pending register, masks them, and
//  raises a one-cycle request toward CP0 for the lowest-numbered enabled source. Holds that
//  source "in service" until CP0 retires it with ERET. Memory-mapped for the data bus.
// PARAMETERS
//  N_SRC    8   total sources; index 0 = internal timer, 1..N_SRC-1 = src_in (2..32)
//  ID_W     3   width of source id field; must satisfy 2**ID_W >= N_SRC
// PORTS
//  clk       in   1        main clock
//  rst       in   1        synchronous reset, active-high
//  src_in    in   N_SRC-1  external requests, synchronous to clk; bit k feeds source k+1
//  mem_en    in   1        bus access strobe
//  mem_we    in   1        1 = write, 0 = read (qualified by mem_en)
//  mem_addr  in   3        word register index
//  mem_din   in   32       write data
//  mem_dout  out  32       read data, registered
//  cpu_ready in   1        CP0 not in a handler (CP0 irout / ir_valid)
//  eret_in   in   1        ERET executing in CP0 this cycle
//  ir_out    out  1        interrupt request pulse to CP0 ir_in
//  cur_id    out  ID_W     id of source in service (valid in REQ/SERVICE)
// BEHAVIOUR
//  Reset: state=IDLE; PEND=0, MASK=0, TCNT=0, TCTRL=0, TCMP=32'hFFFF_FFFF; ir_out=0,
//   cur_id=0, mem_dout=0; src_prev=all ones (lines held high through reset do not fire).
//  Edge capture: at each edge, PEND[k+1] <= 1 if src_in[k] & ~src_prev[k]; src_prev <= src_in.
//  Timer: if TCTRL[0], TCNT increments each cycle (32-bit wrap); when TCNT==TCMP at an edge,
//   TCNT<=0 and PEND[0]<=1. TCNT write takes priority over increment/match that cycle.
//  Register map (mem_addr): 0 PEND R / W1C; 1 MASK RW; 2 STATUS RO {28'b0,state[1:0]} in
//   [1:0], cur_id in [ID_W+7:8]; 3 TCMP RW; 4 TCNT RW; 5 TCTRL RW bit0 only; 6-7 read 0,
//   writes ignored. Bits >= N_SRC of PEND/MASK read 0, writes ignored.
//  Read: edge with mem_en & ~mem_we -> mem_dout = register value; 1-cycle latency; mem_dout
//   holds otherwise. Read of a reg written same cycle returns old value.
//  PEND set/clear priority: hardware set (edge or timer) wins over W1C and over ERET clear.
//  FSM (2-bit state): IDLE=0, REQ=1, SERVICE=2.
//   IDLE: at edge with cpu_ready & |(PEND&MASK): cur_id<=lowest set index of PEND&MASK,
//    ir_out<=1, ->REQ. Selection uses PEND/MASK values before this edge's updates.
//   REQ: next edge: ir_out<=0, ->SERVICE (ir_out high exactly one cycle).
//   SERVICE: edge with eret_in: PEND[cur_id]<=0 (unless set same edge), ->IDLE. eret_in in
//    IDLE/REQ ignored. MASK or PEND writes during REQ/SERVICE do not abort service.
//  Latency: src_in rise sampled at edge t -> PEND set at t -> ir_out high after edge t+1
//   (if IDLE, masked-in, cpu_ready). Back-to-back: next request no earlier than 1 cycle
//   after the ERET edge.
//  Reset mid-operation: any state -> IDLE, pending lost, ir_out drops next edge.
//  STATE value 3 unreachable; treated as IDLE.
// TESTING
//  1 MASK=0x02, pulse src_in[0] high 1 cycle -> PEND=0x02, ir_out 1 cycle, cur_id=1,
//    STATUS[1:0]=2; eret_in 1 cycle -> PEND=0, state IDLE.
//  2 MASK=0xFF, src_in[3] and src_in[1] rise same edge -> cur_id=2 first; after ERET,
//    ir_out again with cur_id=4.
//  3 TCMP=5, TCTRL=1, MASK=0x01 -> PEND[0] set 6 cycles after enable, TCNT reads 0 after
//    match, ir_out with cur_id=0.
//  4 cpu_ready=0 with PEND&MASK!=0 -> ir_out stays 0; raise cpu_ready -> ir_out next cycle.
//  5 In SERVICE for id 1, src_in[0] re-rises on same edge as eret_in -> PEND[1] stays 1,
//    new request issued; W1C 0x02 coincident with new edge -> bit stays 1.
//  6 Assert rst during SERVICE with src_in held high -> all regs reset values, no request
//    after release until src_in falls and rises again.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt source controller: edge-captures external lines and a compare timer into PEND,
// masks them, and hands the lowest enabled source to CP0 until that source is retired by ERET.
module irq_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-2:0] src_in,
    input  logic             mem_en,
    input  logic             mem_we,
    input  logic [2:0]       mem_addr,
    input  logic [31:0]      mem_din,
    output logic [31:0]      mem_dout,
    input  logic             cpu_ready,
    input  logic             eret_in,
    output logic             ir_out,
    output logic [ID_W-1:0]  cur_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        UNUSED  = 2'd3
    } state_e;

    localparam logic [2:0] A_PEND   = 3'd0;
    localparam logic [2:0] A_MASK   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_TCMP   = 3'd3;
    localparam logic [2:0] A_TCNT   = 3'd4;
    localparam logic [2:0] A_TCTRL  = 3'd5;

    state_e            state_q, state_d;
    logic [N_SRC-1:0]  pend_q, pend_d;
    logic [N_SRC-1:0]  mask_q, mask_d;
    logic [N_SRC-2:0]  src_prev_q;
    logic [31:0]       tcnt_q, tcnt_d;
    logic [31:0]       tcmp_q, tcmp_d;
    logic              tctrl_q, tctrl_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic              ir_out_q, ir_out_d;
    logic [31:0]       dout_q, dout_d;

    logic              bus_wr, bus_rd, tcnt_wr, tmr_hit, eret_clr;
    logic [N_SRC-1:0]  hw_set, req_v;
    logic [ID_W-1:0]   sel_id;
    logic [31:0]       rdata;

    // Bus decode, timer and pending-register update.
    always_comb begin
        bus_wr  = mem_en & mem_we;
        bus_rd  = mem_en & ~mem_we;
        tcnt_wr = bus_wr && (mem_addr == A_TCNT);
        // A software TCNT write overrides both the increment and a compare match.
        tmr_hit = tctrl_q && (tcnt_q == tcmp_q) && !tcnt_wr;
        hw_set  = {src_in & ~src_prev_q, tmr_hit};

        tcnt_d = tcnt_q;
        if (tcnt_wr)      tcnt_d = mem_din;
        else if (tmr_hit) tcnt_d = '0;
        else if (tctrl_q) tcnt_d = tcnt_q + 32'd1;

        tcmp_d  = (bus_wr && mem_addr == A_TCMP)  ? mem_din : tcmp_q;
        tctrl_d = (bus_wr && mem_addr == A_TCTRL) ? mem_din[0] : tctrl_q;
        mask_d  = (bus_wr && mem_addr == A_MASK)  ? mem_din[N_SRC-1:0] : mask_q;

        eret_clr = (state_q == SERVICE) && eret_in;
        pend_d   = pend_q;
        if (bus_wr && mem_addr == A_PEND) pend_d = pend_d & ~mem_din[N_SRC-1:0];
        if (eret_clr) pend_d = pend_d & ~(N_SRC'(1) << cur_id_q);
        pend_d = pend_d | hw_set;
    end

    always_comb begin
        req_v  = pend_q & mask_q;
        sel_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_v[i]) sel_id = ID_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        ir_out_d = 1'b0;
        case (state_q)
            REQ:     state_d = SERVICE;
            SERVICE: if (eret_in) state_d = IDLE;
            default: begin
                if (cpu_ready && (|req_v)) begin
                    cur_id_d = sel_id;
                    ir_out_d = 1'b1;
                    state_d  = REQ;
                end
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        case (mem_addr)
            A_PEND:   rdata = 32'(pend_q);
            A_MASK:   rdata = 32'(mask_q);
            A_STATUS: rdata = (32'(cur_id_q) << 8) | 32'(state_q);
            A_TCMP:   rdata = tcmp_q;
            A_TCNT:   rdata = tcnt_q;
            A_TCTRL:  rdata = {31'b0, tctrl_q};
            default:  rdata = '0;
        endcase
        dout_d = bus_rd ? rdata : dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            mask_q     <= '0;
            src_prev_q <= '1;
            tcnt_q     <= '0;
            tcmp_q     <= 32'hFFFF_FFFF;
            tctrl_q    <= 1'b0;
            cur_id_q   <= '0;
            ir_out_q   <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            src_prev_q <= src_in;
            tcnt_q     <= tcnt_d;
            tcmp_q     <= tcmp_d;
            tctrl_q    <= tctrl_d;
            cur_id_q   <= cur_id_d;
            ir_out_q   <= ir_out_d;
            dout_q     <= dout_d;
        end
    end

    assign mem_dout = dout_q;
    assign ir_out   = ir_out_q;
    assign cur_id   = cur_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic, all scored
// against a transaction-level reference model.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  src_in;
    logic        mem_en, mem_we;
    logic [2:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        cpu_ready, eret_in, ir_out;
    logic [2:0]  cur_id;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .src_in(src_in),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .cpu_ready(cpu_ready), .eret_in(eret_in),
        .ir_out(ir_out), .cur_id(cur_id)
    );

    // Reference model: m_st 0 = idle, 1 = request pulse, 2 = in service.
    logic [7:0]  m_pend, m_mask;
    logic [31:0] m_tcmp, m_tcnt, m_dout;
    logic        m_ten, m_ir;
    logic [6:0]  m_prev;
    int          m_st, m_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] hw, p, q;
        logic       hit, twr, wr, clr;
        int         sel;
        if (rst) begin
            m_pend = 0; m_mask = 0; m_tcnt = 0; m_ten = 0; m_tcmp = 32'hFFFF_FFFF;
            m_st = 0; m_id = 0; m_ir = 0; m_dout = 0; m_prev = 7'h7F;
            return;
        end
        wr = mem_en && mem_we;
        if (mem_en && !mem_we) begin
            case (mem_addr)
                3'd0: m_dout = 32'(m_pend);
                3'd1: m_dout = 32'(m_mask);
                3'd2: m_dout = 32'(m_id * 256 + m_st);
                3'd3: m_dout = m_tcmp;
                3'd4: m_dout = m_tcnt;
                3'd5: m_dout = 32'(m_ten);
                default: m_dout = 0;
            endcase
        end
        twr = wr && (mem_addr == 3'd4);
        hit = m_ten && (m_tcnt == m_tcmp) && !twr;
        hw  = {src_in & ~m_prev, hit};
        clr = 0;
        m_ir = 0;
        case (m_st)
            1: m_st = 2;
            2: if (eret_in) begin clr = 1; m_st = 0; end
            default: begin
                q = m_pend & m_mask;
                if (cpu_ready && q != 0) begin
                    sel = 0;
                    while (q[sel] == 1'b0) sel++;
                    m_id = sel; m_ir = 1; m_st = 1;
                end
            end
        endcase
        p = m_pend;
        if (wr && mem_addr == 3'd0) p = p & ~mem_din[7:0];
        if (clr) p[m_id] = 1'b0;
        m_pend = p | hw;
        if (twr)        m_tcnt = mem_din;
        else if (hit)   m_tcnt = 0;
        else if (m_ten) m_tcnt = m_tcnt + 1;
        if (wr && mem_addr == 3'd1) m_mask = mem_din[7:0];
        if (wr && mem_addr == 3'd3) m_tcmp = mem_din;
        if (wr && mem_addr == 3'd5) m_ten  = mem_din[0];
        m_prev = src_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("ir_out", 32'(ir_out), 32'(m_ir));
        chk("cur_id", 32'(cur_id), 32'(m_id));
        chk("mem_dout", mem_dout, m_dout);
    endtask

    task automatic bus_idle();
        mem_en = 0; mem_we = 0; mem_addr = 0; mem_din = 0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        mem_en = 1; mem_we = 1; mem_addr = a; mem_din = d;
        tick();
        bus_idle();
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        mem_en = 1; mem_we = 0; mem_addr = a;
        tick();
        chk(tag, mem_dout, exp);
        bus_idle();
    endtask

    initial begin
        rst = 1; src_in = 0; cpu_ready = 1; eret_in = 0;
        bus_idle();
        tick(); tick();
        rst = 0;
        chk("rst_dout", mem_dout, 32'h0);
        chk("rst_ir", 32'(ir_out), 32'h0);
        rd_chk("rst_tcmp", 3'd3, 32'hFFFF_FFFF);
        rd_chk("rst_status", 3'd2, 32'h0);

        // Single source, full service round trip.
        wr_reg(3'd1, 32'h02);
        src_in = 7'h01; tick();
        src_in = 7'h00; tick();
        chk("t1_ir", 32'(ir_out), 32'h1);
        chk("t1_id", 32'(cur_id), 32'h1);
        tick();
        chk("t1_ir_drop", 32'(ir_out), 32'h0);
        rd_chk("t1_status", 3'd2, 32'h102);
        rd_chk("t1_pend", 3'd0, 32'h02);
        eret_in = 1; tick(); eret_in = 0;
        rd_chk("t1_pend_clr", 3'd0, 32'h0);
        rd_chk("t1_status_idle", 3'd2, 32'h100);

        // Two simultaneous sources: lowest first, the other after ERET.
        wr_reg(3'd1, 32'hFF);
        src_in = 7'b0001010; tick();
        tick();
        chk("t2_id_first", 32'(cur_id), 32'h2);
        tick();
        eret_in = 1; tick(); eret_in = 0;
        tick();
        chk("t2_ir_second", 32'(ir_out), 32'h1);
        chk("t2_id_second", 32'(cur_id), 32'h4);
        tick();
        eret_in = 1; src_in = 0; tick(); eret_in = 0;

        // cpu_ready gating.
        cpu_ready = 0; src_in = 7'h01;
        tick(); tick(); tick();
        chk("t4_blocked", 32'(ir_out), 32'h0);
        cpu_ready = 1; tick();
        chk("t4_ready_ir", 32'(ir_out), 32'h1);
        chk("t4_ready_id", 32'(cur_id), 32'h1);
        tick();

        // Re-rise coincident with ERET keeps the bit; W1C loses to a new edge.
        src_in = 0; tick();
        src_in = 7'h01; eret_in = 1; tick(); eret_in = 0;
        tick();
        chk("t5_rereq", 32'(ir_out), 32'h1);
        chk("t5_rereq_id", 32'(cur_id), 32'h1);
        tick();
        src_in = 0; tick();
        src_in = 7'h01; mem_en = 1; mem_we = 1; mem_addr = 3'd0; mem_din = 32'h02;
        tick(); bus_idle();
        rd_chk("t5_w1c_lose", 3'd0, 32'h02);
        eret_in = 1; tick(); eret_in = 0; src_in = 0;
        rd_chk("t5_pend_clr", 3'd0, 32'h0);

        // Compare timer.
        wr_reg(3'd1, 32'h01);
        wr_reg(3'd3, 32'd5);
        wr_reg(3'd5, 32'd1);
        repeat (6) tick();
        rd_chk("t3_tcnt_zero", 3'd4, 32'h0);
        chk("t3_ir", 32'(ir_out), 32'h1);
        chk("t3_id", 32'(cur_id), 32'h0);
        wr_reg(3'd5, 32'd0);
        eret_in = 1; tick(); eret_in = 0;

        // Reset during service with a line held high.
        wr_reg(3'd1, 32'hFF);
        src_in = 7'h04; tick(); tick(); tick();
        rst = 1; tick(); tick(); rst = 0;
        wr_reg(3'd1, 32'hFF);
        rd_chk("t6_pend_empty", 3'd0, 32'h0);
        chk("t6_no_req", 32'(ir_out), 32'h0);
        src_in = 0; tick();
        src_in = 7'h04; tick();
        rd_chk("t6_pend_new", 3'd0, 32'h08);
        chk("t6_ir", 32'(ir_out), 32'h1);
        chk("t6_id", 32'(cur_id), 32'h3);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            src_in    = src_in ^ (7'($urandom) & 7'($urandom) & 7'($urandom));
            cpu_ready = ($urandom_range(0, 7) != 0);
            eret_in   = ($urandom_range(0, 4) == 0);
            mem_en    = ($urandom_range(0, 2) != 0);
            mem_we    = ($urandom_range(0, 3) == 0);
            mem_addr  = 3'($urandom_range(0, 7));
            case (mem_addr)
                3'd3:    mem_din = $urandom_range(0, 20);
                3'd4:    mem_din = $urandom_range(0, 10);
                default: mem_din = $urandom;
            endcase
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
